// File: rtl/cursor_controller_if.sv
// Bus between the cursor controller and its surroundings: raw buttons, game
// status in; cursor position and placement requests out.
interface cursor_controller_if;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic       btn_select;
   logic       enable;
   logic [8:0] occupied;
   logic [3:0] move;
   logic [9:0] pixel_x;
   logic [9:0] pixel_c;
   logic       place_valid;
   logic [3:0] place_cell;
   logic       place_rejected;

   modport master (
      output btn_up, btn_down, btn_left, btn_right, btn_select,
      output enable, occupied,
      input  move, pixel_x, pixel_c, place_valid, place_cell, place_rejected
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right, btn_select,
      input  enable, occupied,
      output move, pixel_x, pixel_c, place_valid, place_cell, place_rejected
   );
endinterface

// File: rtl/cursor_controller.sv
// Button conditioning (sync, debounce, edge detect) and 3x3 cursor navigation
// with placement requests for the cursor-line overlay stage.
module cursor_controller #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input logic                clk,
   input logic                rst,
   cursor_controller_if.slave bus
);

   localparam int NB = 5;
   localparam int CW = 20;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   localparam int B_UP    = 0;
   localparam int B_DOWN  = 1;
   localparam int B_LEFT  = 2;
   localparam int B_RIGHT = 3;
   localparam int B_SEL   = 4;

   logic [NB-1:0] raw;
   logic [NB-1:0] sync_a;
   logic [NB-1:0] sync_b;
   logic [NB-1:0] stable;
   logic [NB-1:0] stable_q;
   logic [NB-1:0] press;
   logic [CW-1:0] count [NB];

   logic [3:0] move_q;
   logic [9:0] pixel_x_q;
   logic [9:0] pixel_c_q;
   logic       place_valid_q;
   logic       place_rejected_q;
   logic [3:0] place_cell_q;

   logic [1:0] row;
   logic [1:0] col;
   logic [1:0] next_row;
   logic [1:0] next_col;
   logic [3:0] next_move;
   logic       occ_here;
   logic       do_valid;
   logic       do_reject;

   function automatic logic [3:0] cell_of(input logic [1:0] r, input logic [1:0] c);
      return 4'(r) * 4'd3 + 4'(c);
   endfunction

   function automatic logic [9:0] x_of(input logic [1:0] c);
      case (c)
         2'd0:    return 10'd91;
         2'd1:    return 10'd305;
         default: return 10'd518;
      endcase
   endfunction

   function automatic logic [9:0] y_of(input logic [1:0] r);
      case (r)
         2'd0:    return 10'd111;
         2'd1:    return 10'd271;
         default: return 10'd434;
      endcase
   endfunction

   assign raw = {bus.btn_select, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

   // Level only flips after CNT_MAX+1 consecutive disagreeing samples; any agreement restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a   <= '0;
         sync_b   <= '0;
         stable   <= '0;
         stable_q <= '0;
         for (int i = 0; i < NB; i++) begin
            count[i] <= '0;
         end
      end else begin
         sync_a   <= raw;
         sync_b   <= sync_a;
         stable_q <= stable;
         for (int i = 0; i < NB; i++) begin
            if (sync_b[i] == stable[i]) begin
               count[i] <= '0;
            end else if (count[i] == CNT_MAX) begin
               stable[i] <= ~stable[i];
               count[i]  <= '0;
            end else begin
               count[i] <= count[i] + 1'b1;
            end
         end
      end
   end

   assign press    = stable & ~stable_q;
   assign occ_here = |(bus.occupied & (9'd1 << move_q));
   assign row      = 2'(move_q / 4'd3);
   assign col      = 2'(move_q % 4'd3);

   // Single action per cycle, select first; lower-priority presses are simply lost.
   always_comb begin
      next_row  = row;
      next_col  = col;
      do_valid  = 1'b0;
      do_reject = 1'b0;
      if (move_q > 4'd8) begin
         next_row = 2'd1;
         next_col = 2'd1;
      end else if (bus.enable) begin
         if (press[B_SEL]) begin
            if (occ_here) begin
               do_reject = 1'b1;
            end else begin
               do_valid = 1'b1;
            end
         end else if (press[B_UP]) begin
            next_row = (row == 2'd0) ? 2'd2 : row - 2'd1;
         end else if (press[B_DOWN]) begin
            next_row = (row == 2'd2) ? 2'd0 : row + 2'd1;
         end else if (press[B_LEFT]) begin
            next_col = (col == 2'd0) ? 2'd2 : col - 2'd1;
         end else if (press[B_RIGHT]) begin
            next_col = (col == 2'd2) ? 2'd0 : col + 2'd1;
         end
      end
      next_move = cell_of(next_row, next_col);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         move_q           <= 4'd4;
         pixel_x_q        <= 10'd305;
         pixel_c_q        <= 10'd271;
         place_valid_q    <= 1'b0;
         place_rejected_q <= 1'b0;
         place_cell_q     <= 4'd0;
      end else begin
         move_q           <= next_move;
         pixel_x_q        <= x_of(next_col);
         pixel_c_q        <= y_of(next_row);
         place_valid_q    <= do_valid;
         place_rejected_q <= do_reject;
         if (do_valid) begin
            place_cell_q <= move_q;
         end
      end
   end

   assign bus.move           = move_q;
   assign bus.pixel_x        = pixel_x_q;
   assign bus.pixel_c        = pixel_c_q;
   assign bus.place_valid    = place_valid_q;
   assign bus.place_rejected = place_rejected_q;
   assign bus.place_cell     = place_cell_q;

endmodule

// File: tb/tb_cursor_controller.sv
// Scoreboard bench for cursor_controller: stimulus pushes predicted cursor
// events, a monitor pops and compares whenever the DUT moves or pulses.
module tb_cursor_controller;

   localparam int N       = 4;
   localparam int LATENCY = 2 + N + 1;

   typedef struct {
      int         cyc;
      logic [3:0] mv;
      logic       pv;
      logic       pr;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   model_move = 4;
   logic [3:0] prev_move = 4'd4;
   ev_t  exp_q[$];
   int   xs[3] = '{91, 305, 518};
   int   ys[3] = '{111, 271, 434};

   cursor_controller_if bus();

   cursor_controller #(.DEBOUNCE_CYCLES(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic set_btns(input logic [4:0] mask);
      bus.btn_up     = mask[0];
      bus.btn_down   = mask[1];
      bus.btn_left   = mask[2];
      bus.btn_right  = mask[3];
      bus.btn_select = mask[4];
   endtask

   // Reference: the board as row/col arithmetic, highest-priority press wins.
   task automatic model_press(input logic [4:0] mask, input logic en,
                              input logic [8:0] occ, input int when);
      ev_t e;
      int  r, c;
      if (!en || mask == 5'd0) return;
      r = model_move / 3;
      c = model_move % 3;
      e.cyc = when;
      e.pv  = 1'b0;
      e.pr  = 1'b0;
      if (mask[4]) begin
         if (occ[model_move]) e.pr = 1'b1;
         else e.pv = 1'b1;
      end else if (mask[0]) r = (r + 2) % 3;
      else if (mask[1]) r = (r + 1) % 3;
      else if (mask[2]) c = (c + 2) % 3;
      else c = (c + 1) % 3;
      model_move = r * 3 + c;
      e.mv = 4'(model_move);
      exp_q.push_back(e);
   endtask

   task automatic apply_stimulus(input logic [4:0] mask, input int bounces, input int hold,
                                 input logic en, input logic [8:0] occ);
      @(negedge clk);
      bus.enable   = en;
      bus.occupied = occ;
      for (int i = 0; i < bounces; i++) begin
         set_btns(mask);
         @(negedge clk);
         set_btns(5'd0);
         @(negedge clk);
      end
      set_btns(mask);
      model_press(mask, en, occ, cyc + LATENCY);
      repeat (hold) @(negedge clk);
      set_btns(5'd0);
      repeat (12) @(negedge clk);
   endtask

   // Monitor: any move change or placement pulse must match the head of the queue.
   always @(posedge clk) begin
      ev_t e;
      cyc++;
      #1;
      if (rst) begin
         prev_move = bus.move;
      end else begin
         if (bus.move != prev_move || bus.place_valid || bus.place_rejected) begin
            check_output("pulse_exclusive", int'(bus.place_valid & bus.place_rejected), 0);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_event actual move=%0d valid=%0b rejected=%0b required no event (cycle %0d)",
                        bus.move, bus.place_valid, bus.place_rejected, cyc);
            end else begin
               e = exp_q.pop_front();
               check_output("event_cycle", cyc, e.cyc);
               check_output("move", int'(bus.move), int'(e.mv));
               check_output("pixel_x", int'(bus.pixel_x), xs[e.mv % 3]);
               check_output("pixel_c", int'(bus.pixel_c), ys[e.mv / 3]);
               check_output("place_valid", int'(bus.place_valid), int'(e.pv));
               check_output("place_rejected", int'(bus.place_rejected), int'(e.pr));
               if (e.pv) check_output("place_cell", int'(bus.place_cell), int'(e.mv));
            end
         end
         prev_move = bus.move;
      end
   end

   initial begin
      logic [4:0] mask;
      set_btns(5'd0);
      bus.enable   = 1'b1;
      bus.occupied = 9'd0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_output("reset_move", int'(bus.move), 4);
      check_output("reset_pixel_x", int'(bus.pixel_x), 305);
      check_output("reset_pixel_c", int'(bus.pixel_c), 271);
      check_output("reset_place_valid", int'(bus.place_valid), 0);
      check_output("reset_place_rejected", int'(bus.place_rejected), 0);
      rst = 1'b0;
      model_move = 4;
      repeat (4) @(negedge clk);

      apply_stimulus(5'b01000, 0, 20, 1'b1, 9'd0);
      apply_stimulus(5'b01000, 0, 20, 1'b1, 9'd0);
      apply_stimulus(5'b01000, 0, 10, 1'b1, 9'd0);
      apply_stimulus(5'b00001, 2, 15, 1'b1, 9'd0);
      apply_stimulus(5'b00001, 0, 10, 1'b1, 9'd0);
      apply_stimulus(5'b00010, 0, 10, 1'b1, 9'd0);
      apply_stimulus(5'b00010, 0, 10, 1'b1, 9'd0);
      apply_stimulus(5'b10000, 0, 10, 1'b1, 9'd0);
      apply_stimulus(5'b10000, 0, 10, 1'b1, 9'b000010000);
      apply_stimulus(5'b00110, 0, 10, 1'b1, 9'd0);
      apply_stimulus(5'b01000, 0, 10, 1'b0, 9'd0);

      // Reset lands while left is two samples into its debounce.
      @(negedge clk);
      bus.enable = 1'b1;
      set_btns(5'b00100);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_output("midreset_move", int'(bus.move), 4);
      rst = 1'b0;
      model_move = 4;
      model_press(5'b00100, 1'b1, 9'd0, cyc + LATENCY);
      repeat (15) @(negedge clk);
      set_btns(5'd0);
      repeat (12) @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         mask = 5'(1 << $urandom_range(0, 4));
         if ($urandom_range(0, 3) == 0) mask = mask | 5'(1 << $urandom_range(0, 4));
         apply_stimulus(mask, $urandom_range(0, 3), $urandom_range(6, 25),
                        ($urandom_range(0, 7) != 0), 9'($urandom));
      end

      repeat (30) @(negedge clk);
      while (exp_q.size() > 0) begin
         ev_t e;
         e = exp_q.pop_front();
         checks++;
         failures++;
         $display("[TB] FAIL missing_event actual none required move=%0d valid=%0b rejected=%0b at cycle %0d",
                  e.mv, e.pv, e.pr, e.cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cursor_controller.md
Name: cursor_controller

Overview:
- Sits directly upstream of the cursor-line overlay stage and drives its cell index and line-origin coordinates.
- Conditions five raw push-buttons: synchroniser, debouncer, rising-edge detector.
- Keeps the highlighted cell of the 3x3 board, moving it with wrap-around.
- Issues a one-cycle placement request when select is pressed on a free cell.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles before a button level is accepted (10 ms at 50 MHz); legal range 1..2^20.

Ports:
- clk  in  1  system clock (pixel-domain clock)
- rst  in  1  synchronous, active-high reset
- btn_up  in  1  raw asynchronous button, active-high
- btn_down  in  1  raw asynchronous button, active-high
- btn_left  in  1  raw asynchronous button, active-high
- btn_right  in  1  raw asynchronous button, active-high
- btn_select  in  1  raw asynchronous button, active-high
- enable  in  1  1 = navigation and placement allowed; 0 = presses discarded (game over or opponent's turn)
- occupied  in  9  bit n = cell n already holds a mark
- move  out  4  current cell index 0..8 (row*3 + col, row-major from top-left)
- pixel_x  out  10  cursor-line origin x for move
- pixel_c  out  10  cursor-line origin y for move
- place_valid  out  1  one-cycle pulse: placement accepted
- place_cell  out  4  cell of the accepted placement; valid while place_valid = 1
- place_rejected  out  1  one-cycle pulse: select pressed on an occupied cell

Behaviour:
- Reset (clk edge with rst = 1):
  - move = 4, pixel_x = 305, pixel_c = 271.
  - place_valid = 0, place_rejected = 0, place_cell = 0.
  - All synchronisers and debounced levels = 0; all counters = 0.
  - Reset mid-debounce or mid-press discards all pending state. A button still held after reset must be re-qualified and produces a press, because its stable level restarts at 0.
- Synchroniser: two flops per button.
- Debouncer, per button:
  - Holds a stable level and a counter.
  - If synced input equals stable level, counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES - 1, the stable level toggles and the counter clears.
  - A stable toggle therefore occurs DEBOUNCE_CYCLES cycles after the synced input first differs, provided it stays different throughout.
- Edge detect: a press pulse is high for one cycle when the stable level goes 0 -> 1. Releases generate nothing.
- Action arbitration, one action per cycle:
  - Priority: select > up > down > left > right.
  - Lower-priority pulses in the same cycle are dropped, not queued.
  - With enable = 0, all pulses are dropped and move holds.
- Navigation (row = move/3, col = move%3), applied at the clock edge after the press pulse:
  - right: col = (col+1) mod 3
  - left: col = (col+2) mod 3
  - down: row = (row+1) mod 3
  - up: row = (row+2) mod 3
  - Wrap stays in the same row or column (right from 2 -> 0, up from 1 -> 7).
- Coordinate outputs are registered and update on the same edge as move. Total mapping:
  - col 0/1/2 -> pixel_x 91/305/518
  - row 0/1/2 -> pixel_c 111/271/434
- move never leaves 0..8. If it is ever observed outside that range, the next edge forces it to 4.
- Select, on the edge after a select press pulse with enable = 1:
  - If occupied[move] = 0: place_valid = 1 and place_cell = move for exactly one cycle.
  - If occupied[move] = 1: place_rejected = 1 for one cycle.
  - move is unchanged in both cases.
  - place_valid and place_rejected are never high together.
  - occupied is sampled in the cycle of the press pulse.
- Latency from a clean raw 0 -> 1 step to the move/pixel update: 2 (sync) + DEBOUNCE_CYCLES + 1 (edge/register) clock cycles. Placement pulses have the same latency.
- Holding a button produces exactly one action; there is no auto-repeat.

Test Plan:
- DEBOUNCE_CYCLES=4, reset held 3 cycles -> move=4, pixel_x=305, pixel_c=271, place_valid=0, place_rejected=0.
- Clean btn_right press held 20 cycles from move=4 -> move=5, pixel_x=518, pixel_c=271, exactly 7 cycles after the raw edge. Second right press -> move=3, pixel_x=91 (wrap).
- btn_up bouncing 1,0,1,0 with 1-cycle glitches, then held -> exactly one action, move 4 -> 1 (pixel_c=111). Further up press -> move=7 (pixel_c=434).
- btn_select with occupied=9'b000000000 at move=4 -> one-cycle place_valid with place_cell=4. Repeat with occupied[4]=1 -> place_rejected for one cycle, no place_valid, move stays 4.
- btn_left and btn_down qualify in the same cycle at move=4 -> only down applied, move=7. enable=0 then btn_right press -> move stays 7, no pulses.
- Assert rst mid-debounce of btn_left (counter=2) with the button still held -> move=4 after reset, and one left action occurs 7 cycles after rst deasserts.
